// File: rtl/hazard_history_unit_if.sv
// Pipeline-control and history bundle between the hazard/history unit and its
// neighbours: stall requests, decode/resolve branch info, and the resulting controls.
interface hazard_history_unit_if #(
  parameter int NUM_STAGES = 4,
  parameter int IDW        = 4,
  parameter int GHR_LEN    = 64,
  parameter int NUM_FOLD   = 7,
  parameter int FOLD_W     = 10
);
  logic [NUM_STAGES-1:0]      stall_req;
  logic                       dec_valid;
  logic                       dec_taken;
  logic [IDW-1:0]             dec_id;
  logic                       dec_redirect;
  logic [31:0]                dec_target;
  logic                       mp_valid;
  logic [IDW-1:0]             mp_id;
  logic                       mp_outcome;
  logic [31:0]                mp_target;
  logic [NUM_STAGES-1:0]      stall;
  logic [NUM_STAGES-1:0]      flush;
  logic                       pc_we;
  logic [31:0]                pc_new;
  logic [GHR_LEN-1:0]         ghr;
  logic [NUM_FOLD*FOLD_W-1:0] fold;
  logic                       recovering;
  logic [15:0]                mp_count;

  modport master (
    output stall_req, dec_valid, dec_taken, dec_id, dec_redirect, dec_target,
    output mp_valid, mp_id, mp_outcome, mp_target,
    input  stall, flush, pc_we, pc_new, ghr, fold, recovering, mp_count
  );

  modport slave (
    input  stall_req, dec_valid, dec_taken, dec_id, dec_redirect, dec_target,
    input  mp_valid, mp_id, mp_outcome, mp_target,
    output stall, flush, pc_we, pc_new, ghr, fold, recovering, mp_count
  );
endinterface

// File: rtl/hazard_history_unit.sv
// Pipeline stall/flush control plus speculative global branch history with
// folded copies, per-branch checkpoints and misprediction recovery.
//   state     | meaning
//   S_IDLE    | normal fetch, speculative history updates allowed
//   S_RECOVER | fetch held after a misprediction, counter runs down to 0
module hazard_history_unit #(
  parameter int NUM_STAGES    = 4,
  parameter int RESOLVE_STAGE = 2,
  parameter int GHR_LEN       = 64,
  parameter int NUM_FOLD      = 7,
  parameter int FOLD_W        = 10,
  parameter int L1            = 4,
  parameter int ALPHA         = 2,
  parameter int CKPT_DEPTH    = 16,
  parameter int RECOVERY_LAT  = 2
) (
  input logic             clk,
  input logic             rst_n,
  hazard_history_unit_if.slave bus
);
  localparam int FW    = NUM_FOLD * FOLD_W;
  localparam int CW    = GHR_LEN + FW;
  localparam int CNT_W = (RECOVERY_LAT > 1) ? $clog2(RECOVERY_LAT) : 1;

  // Fold lengths past the history length are clamped so the default
  // geometry (7 folds of 4*2^k over 64 bits) still elaborates.
  function automatic int fold_len(input int k);
    int len;
    len = L1;
    for (int j = 0; j < k; j++) begin
      len = len * ALPHA;
      if (len > GHR_LEN) len = GHR_LEN;
    end
    if (len > GHR_LEN) len = GHR_LEN;
    return len;
  endfunction

  function automatic logic [FOLD_W-1:0] fold_step(input logic [FOLD_W-1:0] f,
                                                  input logic nb, input logic ob,
                                                  input int pos);
    logic [FOLD_W-1:0] r;
    r      = {f[FOLD_W-2:0], f[FOLD_W-1]};
    r[0]   = r[0] ^ nb;
    r[pos] = r[pos] ^ ob;
    return r;
  endfunction

  typedef enum logic {S_IDLE, S_RECOVER} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [GHR_LEN-1:0] r_ghr;
  logic [FW-1:0]      r_fold;
  logic [15:0]        r_mp_count;
  logic [CW-1:0]      r_ckpt [CKPT_DEPTH];

  logic [NUM_STAGES-1:0] w_stall_base, w_flush_base, w_stall, w_flush;
  logic                  w_recovering, w_spec_upd, w_hist_upd, w_new_bit;
  logic [GHR_LEN-1:0]    w_ghr_src, w_ghr_next;
  logic [FW-1:0]         w_fold_src, w_fold_next;

  assign w_recovering = (r_state == S_RECOVER);

  always_comb begin
    w_stall_base = '0;
    w_flush_base = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      w_stall_base[i] = |(bus.stall_req >> i);
    for (int i = 0; i < NUM_STAGES - 1; i++)
      w_flush_base[i] = w_stall_base[i] & ~w_stall_base[i+1];
    w_stall = w_stall_base;
    w_flush = w_flush_base;
    if (w_recovering) begin
      w_stall[0] = 1'b1;
      w_flush[0] = 1'b1;
    end
    // A resolved misprediction squashes everything younger than the resolver.
    if (bus.mp_valid) begin
      for (int i = 0; i < RESOLVE_STAGE; i++) begin
        w_stall[i] = 1'b0;
        w_flush[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_spec_upd = bus.dec_valid & ~w_stall_base[1] & ~bus.mp_valid & ~w_recovering;
    w_hist_upd = w_spec_upd | bus.mp_valid;
    w_new_bit  = bus.mp_valid ? bus.mp_outcome : bus.dec_taken;
    {w_ghr_src, w_fold_src} = bus.mp_valid ? r_ckpt[bus.mp_id] : {r_ghr, r_fold};
    w_ghr_next = {w_ghr_src[GHR_LEN-2:0], w_new_bit};
  end

  // Each fold tracks the XOR of FOLD_W-bit chunks of the youngest Lk history bits.
  for (genvar k = 0; k < NUM_FOLD; k++) begin : g_fold
    localparam int LK = fold_len(k);
    assign w_fold_next[k*FOLD_W +: FOLD_W] =
      fold_step(w_fold_src[k*FOLD_W +: FOLD_W], w_new_bit, w_ghr_src[LK-1], LK % FOLD_W);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ghr      <= '0;
      r_fold     <= '0;
      r_mp_count <= '0;
    end else begin
      if (w_hist_upd) begin
        r_ghr  <= w_ghr_next;
        r_fold <= w_fold_next;
      end
      if (bus.mp_valid && r_mp_count != 16'hFFFF)
        r_mp_count <= r_mp_count + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (bus.mp_valid && RECOVERY_LAT > 1) begin
            r_state <= S_RECOVER;
            r_cnt   <= CNT_W'(RECOVERY_LAT - 1);
          end
        end
        S_RECOVER: begin
          if (bus.mp_valid) begin
            r_cnt <= CNT_W'(RECOVERY_LAT - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Checkpoints hold the pre-update history; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_spec_upd) r_ckpt[bus.dec_id] <= {r_ghr, r_fold};
  end

  assign bus.stall      = w_stall;
  assign bus.flush      = w_flush;
  assign bus.pc_we      = bus.mp_valid | (bus.dec_redirect & ~w_stall_base[1] & ~w_recovering);
  assign bus.pc_new     = bus.mp_valid ? bus.mp_target : bus.dec_target;
  assign bus.ghr        = r_ghr;
  assign bus.fold       = r_fold;
  assign bus.recovering = w_recovering;
  assign bus.mp_count   = r_mp_count;
endmodule

// File: tb/tb_hazard_history_unit.sv
// Self-checking bench for hazard_history_unit: directed scenarios plus random
// traffic compared against a history/recovery model built on plain arithmetic.
module tb_hazard_history_unit;
  localparam int NS  = 4;
  localparam int RS  = 2;
  localparam int GL  = 64;
  localparam int NF  = 7;
  localparam int FW  = 10;
  localparam int L1  = 4;
  localparam int ALP = 2;
  localparam int CD  = 16;
  localparam int IDW = 4;
  localparam int LAT = 3;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  logic [GL-1:0] m_ghr;
  logic [GL-1:0] m_ckpt [CD];
  bit            m_wr   [CD];
  int            m_rec;
  int            m_cnt;

  hazard_history_unit_if #(.NUM_STAGES(NS), .IDW(IDW), .GHR_LEN(GL),
                           .NUM_FOLD(NF), .FOLD_W(FW)) hif ();

  hazard_history_unit #(
    .NUM_STAGES(NS), .RESOLVE_STAGE(RS), .GHR_LEN(GL), .NUM_FOLD(NF), .FOLD_W(FW),
    .L1(L1), .ALPHA(ALP), .CKPT_DEPTH(CD), .RECOVERY_LAT(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [FW-1:0] fold_of(input logic [GL-1:0] g, input int k);
    int len;
    logic [FW-1:0] acc;
    len = L1;
    for (int j = 0; j < k; j++) len = len * ALP;
    if (len > GL) len = GL;
    acc = '0;
    for (int p = 0; p < len; p++) acc[p % FW] = acc[p % FW] ^ g[p];
    return acc;
  endfunction

  function automatic void model_next();
    logic spec;
    if (!rst_n) begin
      m_ghr = '0;
      m_rec = 0;
      m_cnt = 0;
      return;
    end
    spec = hif.dec_valid && !(|hif.stall_req[NS-1:1]) && !hif.mp_valid && m_rec == 0;
    if (hif.mp_valid) begin
      m_ghr = {m_ckpt[hif.mp_id][GL-2:0], hif.mp_outcome};
      m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
      m_rec = LAT - 1;
    end else begin
      if (spec) begin
        m_ckpt[hif.dec_id] = m_ghr;
        m_wr[hif.dec_id]   = 1'b1;
        m_ghr = {m_ghr[GL-2:0], hif.dec_taken};
      end
      if (m_rec > 0) m_rec = m_rec - 1;
    end
  endfunction

  function automatic void exp_comb(output logic [NS-1:0] es, output logic [NS-1:0] ef,
                                   output logic epw, output logic [31:0] epn);
    logic [NS-1:0] base;
    for (int i = 0; i < NS; i++) begin
      base[i] = 1'b0;
      for (int j = i; j < NS; j++) base[i] = base[i] | hif.stall_req[j];
    end
    ef = '0;
    for (int i = 0; i < NS - 1; i++) ef[i] = base[i] & ~base[i+1];
    es = base;
    if (m_rec > 0) begin
      es[0] = 1'b1;
      ef[0] = 1'b1;
    end
    if (hif.mp_valid) begin
      for (int i = 0; i < RS; i++) begin
        es[i] = 1'b0;
        ef[i] = 1'b1;
      end
    end
    epw = hif.mp_valid | (hif.dec_redirect & ~base[1] & (m_rec == 0));
    epn = hif.mp_valid ? hif.mp_target : hif.dec_target;
  endfunction

  task automatic drive_idle();
    hif.stall_req    = '0;
    hif.dec_valid    = 1'b0;
    hif.dec_taken    = 1'b0;
    hif.dec_id       = '0;
    hif.dec_redirect = 1'b0;
    hif.dec_target   = '0;
    hif.mp_valid     = 1'b0;
    hif.mp_id        = '0;
    hif.mp_outcome   = 1'b0;
    hif.mp_target    = '0;
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic decode(input int id, input logic taken);
    hif.dec_valid = 1'b1;
    hif.dec_id    = IDW'(id);
    hif.dec_taken = taken;
    tick();
    hif.dec_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if (hif.ghr !== '0) $display("FAIL reset_ghr got=%h want=0", hif.ghr);
    else n_pass++;
    n_total++;
    if (hif.fold !== '0) $display("FAIL reset_fold got=%h want=0", hif.fold);
    else n_pass++;
    n_total++;
    if (hif.recovering !== 1'b0) $display("FAIL reset_recovering got=%b want=0", hif.recovering);
    else n_pass++;
    n_total++;
    if (hif.mp_count !== 16'h0) $display("FAIL reset_mp_count got=%h want=0", hif.mp_count);
    else n_pass++;
    hif.stall_req = 4'b0100;
    #1;
    n_total++;
    if (hif.stall !== 4'b0111 || hif.flush !== 4'b0100)
      $display("FAIL reset_comb_stall got=%b/%b want=0111/0100", hif.stall, hif.flush);
    else n_pass++;
    drive_idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fold_fill();
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      decode(c, 1'b1);
      for (int k = 0; k < NF; k++) begin
        n_total++;
        if (hif.fold[k*FW +: FW] !== fold_of(m_ghr, k))
          $display("FAIL fill_fold%0d cyc%0d got=%h want=%h", k, c, hif.fold[k*FW +: FW], fold_of(m_ghr, k));
        else n_pass++;
      end
    end
    n_total++;
    if (hif.ghr !== 64'hFF) $display("FAIL fill_ghr got=%h want=ff", hif.ghr);
    else n_pass++;
    n_total++;
    if (hif.fold[0 +: FW] !== 10'h00F) $display("FAIL fill_fold0 got=%h want=00f", hif.fold[0 +: FW]);
    else n_pass++;
    n_total++;
    if (hif.fold[FW +: FW] !== 10'h0FF) $display("FAIL fill_fold1 got=%h want=0ff", hif.fold[FW +: FW]);
    else n_pass++;
  endtask

  task automatic test_stall_flush();
    logic [NS-1:0] es, ef;
    logic epw;
    logic [31:0] epn;
    drive_idle();
    hif.stall_req = 4'b0100;
    #1;
    n_total++;
    if (hif.stall !== 4'b0111 || hif.flush !== 4'b0100)
      $display("FAIL sf_0100 got=%b/%b want=0111/0100", hif.stall, hif.flush);
    else n_pass++;
    hif.stall_req = 4'b1000;
    #1;
    n_total++;
    if (hif.stall !== 4'b1111 || hif.flush !== 4'b0000)
      $display("FAIL sf_1000 got=%b/%b want=1111/0000", hif.stall, hif.flush);
    else n_pass++;
    tick();
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 16; s++) begin
        hif.stall_req    = NS'(s);
        hif.mp_valid     = (m == 1);
        hif.mp_id        = '0;
        hif.mp_target    = $urandom;
        hif.dec_redirect = 1'b1;
        hif.dec_target   = $urandom;
        #1;
        exp_comb(es, ef, epw, epn);
        n_total++;
        if (hif.stall !== es || hif.flush !== ef || hif.pc_we !== epw || hif.pc_new !== epn)
          $display("FAIL sf_sweep sr=%b mp=%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", s[3:0], m,
                   hif.stall, hif.flush, hif.pc_we, hif.pc_new, es, ef, epw, epn);
        else n_pass++;
        tick();
      end
    end
    drive_idle();
    for (int c = 0; c < LAT; c++) tick();
  endtask

  task automatic test_mispredict();
    logic [GL-1:0] g3;
    logic [31:0] tgt;
    int cnt0;
    apply_reset();
    for (int i = 0; i < 3; i++) decode(i, 1'($urandom));
    g3 = m_ghr;
    decode(3, 1'b1);
    decode(4, 1'b1);
    cnt0 = m_cnt;
    tgt = 32'hA5A5_0000 ^ $urandom;
    hif.mp_valid = 1'b1; hif.mp_id = 4'd3; hif.mp_outcome = 1'b0; hif.mp_target = tgt;
    hif.dec_redirect = 1'b1; hif.dec_target = 32'h0000_1234;
    hif.dec_valid = 1'b1; hif.dec_id = 4'd7; hif.dec_taken = 1'b1;
    #1;
    n_total++;
    if (hif.pc_we !== 1'b1 || hif.pc_new !== tgt)
      $display("FAIL mp_pc got=%b/%h want=1/%h", hif.pc_we, hif.pc_new, tgt);
    else n_pass++;
    n_total++;
    if (hif.flush[1:0] !== 2'b11 || hif.stall[1:0] !== 2'b00)
      $display("FAIL mp_flush got=%b/%b want=11/00", hif.flush[1:0], hif.stall[1:0]);
    else n_pass++;
    tick();
    drive_idle();
    hif.dec_valid = 1'b1; hif.dec_id = 4'd8; hif.dec_taken = 1'b1;
    n_total++;
    if (hif.ghr !== {g3[GL-2:0], 1'b0}) $display("FAIL mp_restore got=%h want=%h", hif.ghr, {g3[GL-2:0], 1'b0});
    else n_pass++;
    n_total++;
    if (hif.fold[2*FW +: FW] !== fold_of({g3[GL-2:0], 1'b0}, 2))
      $display("FAIL mp_fold2 got=%h want=%h", hif.fold[2*FW +: FW], fold_of({g3[GL-2:0], 1'b0}, 2));
    else n_pass++;
    n_total++;
    if (hif.mp_count !== 16'(cnt0 + 1)) $display("FAIL mp_count got=%0d want=%0d", hif.mp_count, cnt0 + 1);
    else n_pass++;
    n_total++;
    if (hif.recovering !== 1'b1) $display("FAIL rec_t1 got=%b want=1", hif.recovering);
    else n_pass++;
    #1;
    n_total++;
    if (hif.stall[0] !== 1'b1 || hif.flush[0] !== 1'b1)
      $display("FAIL rec_hold_t1 got=%b/%b want=1/1", hif.stall[0], hif.flush[0]);
    else n_pass++;
    tick();
    hif.dec_valid = 1'b0;
    n_total++;
    if (hif.ghr !== {g3[GL-2:0], 1'b0}) $display("FAIL rec_dec_dropped got=%h want=%h", hif.ghr, {g3[GL-2:0], 1'b0});
    else n_pass++;
    n_total++;
    if (hif.recovering !== 1'b1) $display("FAIL rec_t2 got=%b want=1", hif.recovering);
    else n_pass++;
    #1;
    n_total++;
    if (hif.stall[0] !== 1'b1 || hif.flush[0] !== 1'b1)
      $display("FAIL rec_hold_t2 got=%b/%b want=1/1", hif.stall[0], hif.flush[0]);
    else n_pass++;
    tick();
    n_total++;
    if (hif.recovering !== 1'b0) $display("FAIL rec_t3 got=%b want=0", hif.recovering);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [GL-1:0] g6;
    logic [31:0] tgt;
    apply_reset();
    decode(5, 1'($urandom));
    g6 = m_ghr;
    decode(6, 1'($urandom));
    decode(7, 1'b1);
    hif.mp_valid = 1'b1; hif.mp_id = 4'd5; hif.mp_outcome = 1'b1; hif.mp_target = 32'h0000_8000;
    tick();
    tgt = $urandom;
    hif.mp_id = 4'd6; hif.mp_outcome = 1'b1; hif.mp_target = tgt;
    hif.dec_redirect = 1'b1; hif.dec_target = ~tgt;
    #1;
    n_total++;
    if (hif.pc_new !== tgt || hif.pc_we !== 1'b1)
      $display("FAIL b2b_pc got=%b/%h want=1/%h", hif.pc_we, hif.pc_new, tgt);
    else n_pass++;
    tick();
    drive_idle();
    n_total++;
    if (hif.ghr !== {g6[GL-2:0], 1'b1}) $display("FAIL b2b_restore got=%h want=%h", hif.ghr, {g6[GL-2:0], 1'b1});
    else n_pass++;
    n_total++;
    if (hif.recovering !== 1'b1) $display("FAIL b2b_t2 got=%b want=1", hif.recovering);
    else n_pass++;
    tick();
    n_total++;
    if (hif.recovering !== 1'b1) $display("FAIL b2b_t3 got=%b want=1", hif.recovering);
    else n_pass++;
    tick();
    n_total++;
    if (hif.recovering !== 1'b0) $display("FAIL b2b_t4 got=%b want=0", hif.recovering);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [NS-1:0] es, ef;
    logic epw;
    logic [31:0] epn;
    int id;
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      drive_idle();
      hif.stall_req    = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      hif.dec_valid    = 1'($urandom);
      hif.dec_taken    = 1'($urandom);
      hif.dec_id       = IDW'($urandom);
      hif.dec_redirect = 1'($urandom);
      hif.dec_target   = $urandom;
      hif.mp_target    = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        id = $urandom_range(0, CD - 1);
        for (int j = 0; j < CD; j++) begin
          if (m_wr[(id + j) % CD]) begin
            hif.mp_valid   = 1'b1;
            hif.mp_id      = IDW'((id + j) % CD);
            hif.mp_outcome = 1'($urandom);
            break;
          end
        end
      end
      #1;
      exp_comb(es, ef, epw, epn);
      n_total++;
      if (hif.stall !== es || hif.flush !== ef || hif.pc_we !== epw || hif.pc_new !== epn)
        $display("FAIL rnd_comb cyc%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", c,
                 hif.stall, hif.flush, hif.pc_we, hif.pc_new, es, ef, epw, epn);
      else n_pass++;
      tick();
      n_total++;
      if (hif.ghr !== m_ghr || hif.recovering !== (m_rec > 0) || hif.mp_count !== 16'(m_cnt))
        $display("FAIL rnd_state cyc%0d got=%h/%b/%0d want=%h/%b/%0d", c,
                 hif.ghr, hif.recovering, hif.mp_count, m_ghr, (m_rec > 0), m_cnt);
      else n_pass++;
      for (int k = 0; k < NF; k++) begin
        n_total++;
        if (hif.fold[k*FW +: FW] !== fold_of(m_ghr, k))
          $display("FAIL rnd_fold%0d cyc%0d got=%h want=%h", k, c, hif.fold[k*FW +: FW], fold_of(m_ghr, k));
        else n_pass++;
      end
    end
    drive_idle();
  endtask

  task automatic test_saturate();
    apply_reset();
    decode(0, 1'b1);
    hif.mp_valid = 1'b1;
    hif.mp_id    = 4'd0;
    for (int c = 0; c < 65535; c++) tick();
    n_total++;
    if (hif.mp_count !== 16'hFFFF) $display("FAIL sat_reach got=%h want=ffff", hif.mp_count);
    else n_pass++;
    tick();
    n_total++;
    if (hif.mp_count !== 16'hFFFF) $display("FAIL sat_hold got=%h want=ffff", hif.mp_count);
    else n_pass++;
    drive_idle();
    n_total++;
    if (hif.recovering !== 1'b1) $display("FAIL sat_in_recover got=%b want=1", hif.recovering);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_total++;
    if (hif.recovering !== 1'b0 || hif.ghr !== '0)
      $display("FAIL rst_mid_recover got=%b/%h want=0/0", hif.recovering, hif.ghr);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_ghr   = '0;
    m_rec   = 0;
    m_cnt   = 0;
    for (int i = 0; i < CD; i++) begin
      m_ckpt[i] = '0;
      m_wr[i]   = 1'b0;
    end
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_fold_fill();
    test_stall_flush();
    test_mispredict();
    test_back_to_back();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
